// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID signal bundle
interface fetch_stage_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              stall;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              halt_req;
   logic [ADDR_W-1:0] i_mem_addr;
   logic [31:0]       i_mem_data;
   logic [31:0]       pc;
   logic              if_id_valid;
   logic [31:0]       if_id_instr;
   logic [31:0]       if_id_pc;
   logic [31:0]       if_id_pc4;
   logic              fault;
   logic [31:0]       fault_pc;
   logic [1:0]        state_o;

   modport master (
      output start, stall, redirect_valid, redirect_pc, halt_req, i_mem_data,
      input  i_mem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
             fault, fault_pc, state_o
   );

   modport slave (
      input  start, stall, redirect_valid, redirect_pc, halt_req, i_mem_data,
      output i_mem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4,
             fault, fault_pc, state_o
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect/halt/fault handling
module fetch_stage #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic        out_of_range;

   // Any set bit above the word-address field means the PC lies past the end of memory.
   assign out_of_range = |pc_q[31:ADDR_W+2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         ipc_q      <= 32'h0;
         ipc4_q     <= 32'h0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         ipc_q      <= ipc_d;
         ipc4_q     <= ipc4_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      ipc4_d     = ipc4_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (bus.start) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
               state_d    = S_FAULT;
               fault_d    = 1'b1;
               fault_pc_d = bus.redirect_pc;
               valid_d    = 1'b0;
            end else if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               valid_d = 1'b0;
            end else if (bus.halt_req) begin
               state_d = S_HALTED;
               valid_d = 1'b0;
            end else if (bus.stall) begin
               valid_d = valid_q;
            end else if (out_of_range) begin
               state_d    = S_FAULT;
               fault_d    = 1'b1;
               fault_pc_d = pc_q;
               valid_d    = 1'b0;
            end else begin
               instr_d = bus.i_mem_data;
               ipc_d   = pc_q;
               ipc4_d  = pc_q + 32'd4;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
            end
         end
         default: valid_d = 1'b0;
      endcase
   end

   assign bus.i_mem_addr  = pc_q[ADDR_W+1:2];
   assign bus.pc          = pc_q;
   assign bus.if_id_valid = valid_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc    = ipc_q;
   assign bus.if_id_pc4   = ipc4_q;
   assign bus.fault       = fault_q;
   assign bus.fault_pc    = fault_pc_q;
   assign bus.state_o     = state_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a rule-level model
module tb_fetch_stage;
   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if #(.ADDR_W(AW)) bus ();
   logic [31:0] mem [DEPTH];
   assign bus.i_mem_data = mem[bus.i_mem_addr];

   fetch_stage #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: state as the numeric code reported on state_o.
   int          m_state;
   logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fpc;
   logic        m_valid, m_fault;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ":state"}, {30'd0, bus.state_o}, 32'(m_state));
      chk({where, ":pc"}, bus.pc, m_pc);
      chk({where, ":addr"}, {26'd0, bus.i_mem_addr}, {26'd0, m_pc[7:2]});
      chk({where, ":valid"}, {31'd0, bus.if_id_valid}, {31'd0, m_valid});
      chk({where, ":instr"}, bus.if_id_instr, m_instr);
      chk({where, ":if_pc"}, bus.if_id_pc, m_ipc);
      chk({where, ":if_pc4"}, bus.if_id_pc4, m_ipc4);
      chk({where, ":fault"}, {31'd0, bus.fault}, {31'd0, m_fault});
      chk({where, ":fault_pc"}, bus.fault_pc, m_fpc);
   endtask

   task automatic model_reset();
      m_state = 0; m_pc = 32'h0; m_valid = 1'b0;
      m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_fault = 1'b0; m_fpc = 32'h0;
   endtask

   task automatic model_edge();
      if (m_state == 0) begin
         m_valid = 1'b0;
         if (bus.start) m_state = 1;
      end else if (m_state == 1) begin
         if (bus.redirect_valid && (bus.redirect_pc % 4 != 0)) begin
            m_state = 3; m_fault = 1'b1; m_fpc = bus.redirect_pc; m_valid = 1'b0;
         end else if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc; m_valid = 1'b0;
         end else if (bus.halt_req) begin
            m_state = 2; m_valid = 1'b0;
         end else if (bus.stall) begin
            // everything holds
         end else if (64'(m_pc) >= 64'(4 * DEPTH)) begin
            m_state = 3; m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0;
         end else begin
            m_instr = mem[m_pc / 4]; m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_valid = 1'b1; m_pc = m_pc + 4;
         end
      end else begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick(input string where);
      model_edge();
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0; bus.halt_req = 1'b0;
   endtask

   task automatic async_reset(input string where);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(where);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] target, input string where);
      bus.redirect_valid = 1'b1; bus.redirect_pc = target;
      tick(where);
      bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[5] = 32'h0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      tick("idle_hold");
      bus.start = 1'b1;
      tick("start");
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick("seq");

      for (int i = 0; i < 16 && m_pc != 32'd32; i++) tick("to32");
      chk("reach32", bus.pc, 32'd32);
      bus.stall = 1'b1;
      repeat (3) tick("stall");
      bus.stall = 1'b0;
      tick("after_stall");

      redirect(32'd44, "redir44");
      tick("cap44");

      bus.stall = 1'b1; bus.halt_req = 1'b1;
      redirect(32'd8, "redir_wins");
      idle_inputs();
      tick("after_win");

      // Randomized run; terminal states are observed frozen, then reset and restarted.
      for (int n = 0; n < 400; n++) begin
         bus.start = 1'($urandom_range(0, 1));
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.redirect_valid = ($urandom_range(0, 9) == 0);
         bus.redirect_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
         if ($urandom_range(0, 29) == 0) bus.redirect_pc = bus.redirect_pc | 32'($urandom_range(1, 3));
         bus.halt_req = ($urandom_range(0, 59) == 0);
         tick("rand");
         if (m_state >= 2) begin
            bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd16;
            tick("rand_frozen");
            idle_inputs();
            async_reset("rand_reset");
            bus.start = 1'b1;
            tick("rand_restart");
         end
      end
      idle_inputs();

      for (int i = 0; i < 4 && !(m_state == 1 && m_valid); i++) tick("pre_rst");
      async_reset("reset_mid_run");
      tick("post_rst_idle");
      bus.start = 1'b1;
      tick("start2");
      bus.start = 1'b0;
      redirect(32'd252, "redir252");
      tick("cap252");
      tick("oor256");
      chk("oor_fault_pc", bus.fault_pc, 32'd256);
      bus.start = 1'b1;
      redirect(32'd8, "fault_frozen");
      idle_inputs();

      async_reset("reset_fault");
      bus.start = 1'b1;
      tick("start3");
      bus.start = 1'b0;
      redirect(32'h0000000A, "misaligned");
      bus.start = 1'b1;
      redirect(32'd8, "mis_frozen");
      idle_inputs();

      async_reset("reset_mis");
      bus.start = 1'b1;
      tick("start4");
      bus.start = 1'b0;
      repeat (3) tick("run4");
      bus.halt_req = 1'b1;
      tick("halt");
      bus.halt_req = 1'b0; bus.start = 1'b1;
      tick("halt_frozen");
      idle_inputs();
      async_reset("reset_halted");
      tick("idle_after_halt");
      bus.start = 1'b1;
      tick("start5");
      bus.start = 1'b0;
      tick("fetch5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the single-issue RISC-V core.
- Holds the program counter (PC) and drives the word address of the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register for the decoder.
- Accepts stall from the hazard unit, redirects (branch/jal/jalr) from execute, and a halt request; reports a fetch fault on bad PCs.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (memory depth 2^ADDR_W words).
- RESET_PC, 32'h0, byte PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- stall  in  1  hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  32  byte target of the redirect.
- halt_req  in  1  stop fetching permanently (until reset).
- i_mem_addr  out  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
- i_mem_data  in  32  instruction word from memory, same cycle.
- pc  out  32  current fetch PC (byte address).
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  32  fetched instruction.
- if_id_pc  out  32  byte PC of if_id_instr.
- if_id_pc4  out  32  if_id_pc + 4 (link value for jal/jalr).
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending PC.
- state_o  out  2  IDLE=0, RUN=1, HALTED=2, FAULT=3.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, pc=RESET_PC;
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0;
  - fault=0, fault_pc=0.
- i_mem_addr is purely combinational from pc. Memory read is zero-latency, so the instruction at pc is captured on the same edge that advances pc.
- IDLE: pc holds, if_id_valid=0. start=1 -> RUN on the next edge; no fetch occurs on that edge.
- RUN: exactly one action per edge, highest priority first:
  1. redirect_valid=1 and redirect_pc[1:0]!=0 -> FAULT, fault=1, fault_pc=redirect_pc, if_id_valid=0.
  2. redirect_valid=1 (aligned) -> pc=redirect_pc, if_id_valid=0 (flush the wrong-path slot). Stall is ignored.
  3. halt_req=1 -> HALTED, if_id_valid=0, pc holds.
  4. stall=1 -> pc and all if_id_* hold their values (including if_id_valid).
  5. pc >= 4*2^ADDR_W (out of range) -> FAULT, fault_pc=pc, if_id_valid=0.
  6. Otherwise -> if_id_instr=i_mem_data, if_id_pc=pc, if_id_pc4=pc+4, if_id_valid=1, pc=pc+4.
- PC arithmetic is 32-bit modulo 2^32. Upper pc bits are not truncated; out-of-range is caught by rule 5, never by address wrap.
- An all-zero instruction word is fetched like any other word; no special handling.
- HALTED and FAULT are terminal until reset:
  - if_id_valid=0, pc frozen, all inputs ignored;
  - fault and fault_pc stay stable.
- Reset asserted mid-RUN clears the pipeline register immediately (async). After release, fetch restarts at RESET_PC only after a new start.
- if_id_instr, if_id_pc and if_id_pc4 keep their last values when if_id_valid drops. Consumers must qualify them with if_id_valid.

Test Plan:
- Reset, start, memory words W0..W3 at words 0..3, no stall -> if_id_valid=1 from the 2nd edge after start. Captures are (pc 0, W0), (4, W1), (8, W2), (12, W3); if_id_pc4 = 4, 8, 12, 16; i_mem_addr steps 0,1,2,3.
- In RUN at pc=32, assert stall for 3 cycles -> pc stays 32, IF/ID unchanged and valid. After release the next capture is pc=32 with mem[8].
- At pc=36, pulse redirect_valid with redirect_pc=44 -> next edge: if_id_valid=0, pc=44. The following edge captures mem[11] with if_id_pc=44 and if_id_pc4=48.
- redirect_valid=1 together with stall=1 and halt_req=1, redirect_pc=8 -> redirect wins: pc=8, state stays RUN, if_id_valid=0.
- redirect_pc=0x0000000A -> state=FAULT, fault=1, fault_pc=0x0A. A later start or redirect has no effect.
- ADDR_W=6, redirect to 252 -> mem[63] captured with pc 252. Next edge pc=256 -> FAULT, fault_pc=256.
- halt_req in RUN -> HALTED, if_id_valid=0. Drop rst_n mid-HALTED -> all outputs at reset values asynchronously. After release, IDLE until start.
